// File: rtl/ecc_error_monitor.sv
// ECC error monitor: one-deep register slice for decoded words, saturating
// corrected/uncorrectable counters, first-failure address capture and health FSM.
module ecc_error_monitor #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned THRESHOLD  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_err_det,
  input  logic                  in_err_cor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_uncor,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  cor_cnt,
  output logic [CNT_WIDTH-1:0]  uncor_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_addr_vld,
  output logic [1:0]            state,
  output logic                  irq
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    ALERT  = 2'b01,
    FATAL  = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] THR     = CNT_WIDTH'(THRESHOLD);

  state_t                  st, st_nx;
  logic                    accept, is_cor, is_uncor;
  logic [CNT_WIDTH-1:0]    cor_nx, uncor_nx;
  logic [ADDR_WIDTH-1:0]   fa_nx;
  logic                    fv_nx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_cor   = in_err_cor;
  assign is_uncor = in_err_det && !in_err_cor;
  assign state    = st;

  // clr selects zeroed bases first so a beat in the same cycle lands on top of them
  always_comb begin
    cor_nx   = clr ? '0 : cor_cnt;
    uncor_nx = clr ? '0 : uncor_cnt;
    fa_nx    = clr ? '0 : fail_addr;
    fv_nx    = clr ? 1'b0 : fail_addr_vld;
    st_nx    = clr ? NORMAL : st;
    if (accept && is_cor && cor_nx != CNT_MAX)
      cor_nx = cor_nx + 1'b1;
    if (accept && is_uncor) begin
      if (uncor_nx != CNT_MAX)
        uncor_nx = uncor_nx + 1'b1;
      if (!fv_nx) begin
        fa_nx = in_addr;
        fv_nx = 1'b1;
      end
      st_nx = FATAL;
    end else if (st_nx == NORMAL && cor_nx >= THR) begin
      st_nx = ALERT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_uncor <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_uncor <= is_uncor;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cor_cnt       <= '0;
      uncor_cnt     <= '0;
      fail_addr     <= '0;
      fail_addr_vld <= 1'b0;
      st            <= NORMAL;
      irq           <= 1'b0;
    end else begin
      cor_cnt       <= cor_nx;
      uncor_cnt     <= uncor_nx;
      fail_addr     <= fa_nx;
      fail_addr_vld <= fv_nx;
      st            <= st_nx;
      irq           <= (st_nx != NORMAL);
    end
  end

endmodule

// File: tb/tb_ecc_error_monitor.sv
// Self-checking bench for ecc_error_monitor: table-driven beats, directed
// corner sequences and a per-cycle scoreboard of forwarded words and status.
module tb_ecc_error_monitor;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int CW = 8;
  localparam int TH = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_err_det = 1'b0, in_err_cor = 1'b0;
  logic          out_ready = 1'b1, clr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  logic          in_ready, out_valid, out_uncor, fail_addr_vld, irq;
  logic [DW-1:0] out_data;
  logic [CW-1:0] cor_cnt, uncor_cnt;
  logic [AW-1:0] fail_addr;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  ecc_error_monitor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .THRESHOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .in_err_det(in_err_det), .in_err_cor(in_err_cor),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_uncor(out_uncor),
    .clr(clr), .cor_cnt(cor_cnt), .uncor_cnt(uncor_cnt),
    .fail_addr(fail_addr), .fail_addr_vld(fail_addr_vld), .state(state), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected forwarded words and expected status registers
  typedef struct packed { logic [DW-1:0] data; logic uncor; } word_t;
  word_t q[$];
  int m_cor = 0, m_uncor = 0, m_fa = 0, m_fv = 0, m_st = 0;

  always begin
    logic acc, fire, uc;
    word_t w;
    @(negedge clk);
    acc  = in_valid & in_ready;
    fire = out_valid & out_ready;
    uc   = in_err_det & ~in_err_cor;
    if (!rst_n) begin
      q.delete();
      m_cor = 0; m_uncor = 0; m_fa = 0; m_fv = 0; m_st = 0;
    end else begin
      chk("sb_out_valid", out_valid, (q.size() != 0));
      chk("sb_in_ready", in_ready, (q.size() == 0) || out_ready);
      if (fire) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_word", 1, 0);
        end else begin
          w = q.pop_front();
          chk("sb_out_data", out_data, w.data);
          chk("sb_out_uncor", out_uncor, w.uncor);
        end
      end
      if (clr) begin
        m_cor = 0; m_uncor = 0; m_fa = 0; m_fv = 0; m_st = 0;
      end
      if (acc) begin
        w.data = in_data; w.uncor = uc;
        q.push_back(w);
        if (in_err_cor && m_cor < CMAX) m_cor++;
        if (uc) begin
          if (m_uncor < CMAX) m_uncor++;
          if (m_fv == 0) begin m_fa = in_addr; m_fv = 1; end
          m_st = 2;
        end
      end
      if (!(acc && uc) && m_st == 0 && m_cor >= TH) m_st = 1;
    end
    @(posedge clk);
    #1;
    chk("sb_cor_cnt", cor_cnt, m_cor);
    chk("sb_uncor_cnt", uncor_cnt, m_uncor);
    chk("sb_fail_addr", fail_addr, m_fa);
    chk("sb_fail_addr_vld", fail_addr_vld, m_fv);
    chk("sb_state", state, m_st);
    chk("sb_irq", irq, (m_st != 0));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic det, input logic cor,
                       input logic [DW-1:0] d, input logic [AW-1:0] a, input logic c);
    #1;
    in_valid = v; in_err_det = det; in_err_cor = cor;
    in_data = d; in_addr = a; clr = c;
  endtask

  typedef struct {
    logic          det, cor;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [CW-1:0] e_cor, e_uncor;
    logic [1:0]    e_state;
  } vec_t;

  vec_t tbl[6];
  logic [CW-1:0] c0, u0;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 8'h11, 10'h001, 8'd0, 8'd0, 2'b00};
    tbl[1] = '{1'b0, 1'b0, 8'h22, 10'h002, 8'd0, 8'd0, 2'b00};
    tbl[2] = '{1'b0, 1'b0, 8'h33, 10'h003, 8'd0, 8'd0, 2'b00};
    tbl[3] = '{1'b0, 1'b0, 8'h44, 10'h004, 8'd0, 8'd0, 2'b00};
    tbl[4] = '{1'b0, 1'b1, 8'h55, 10'h005, 8'd1, 8'd0, 2'b00};
    tbl[5] = '{1'b1, 1'b1, 8'h66, 10'h006, 8'd2, 8'd0, 2'b00};

    tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state", state, 0);
    drive(0, 0, 0, '0, '0, 0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) begin
      drive(1, tbl[i].det, tbl[i].cor, tbl[i].data, tbl[i].addr, 0);
      tick;
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_out_data", out_data, tbl[i].data);
      chk("tbl_cor_cnt", cor_cnt, tbl[i].e_cor);
      chk("tbl_uncor_cnt", uncor_cnt, tbl[i].e_uncor);
      chk("tbl_state", state, tbl[i].e_state);
      chk("tbl_irq", irq, 0);
    end

    // threshold crossing
    drive(0, 0, 0, '0, '0, 1);
    tick;
    chk("clr_cor_cnt", cor_cnt, 0);
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 1, DW'(i), AW'(i), 0);
      tick;
    end
    chk("thr15_state", state, 0);
    chk("thr15_cor_cnt", cor_cnt, 15);
    drive(1, 0, 1, 8'hA0, 10'h010, 0);
    tick;
    chk("thr16_state", state, 1);
    chk("thr16_irq", irq, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, DW'(i), AW'(i), 0);
      tick;
    end
    chk("alert_cor20", cor_cnt, 20);
    chk("alert_state", state, 1);

    // clr together with an uncorrectable beat
    drive(1, 1, 0, 8'hEE, 10'h3FF, 1);
    tick;
    chk("clrbeat_cor_cnt", cor_cnt, 0);
    chk("clrbeat_uncor_cnt", uncor_cnt, 1);
    chk("clrbeat_fail_addr", fail_addr, 10'h3FF);
    chk("clrbeat_state", state, 2);

    // first-failure capture
    drive(0, 0, 0, '0, '0, 1);
    tick;
    chk("clr_state", state, 0);
    chk("clr_fail_vld", fail_addr_vld, 0);
    drive(1, 1, 0, 8'h5A, 10'h05A, 0);
    tick;
    chk("unc1_out_uncor", out_uncor, 1);
    chk("unc1_state", state, 2);
    drive(1, 1, 0, 8'h33, 10'h133, 0);
    tick;
    chk("unc2_out_uncor", out_uncor, 1);
    chk("unc2_fail_addr", fail_addr, 10'h05A);
    chk("unc2_fail_vld", fail_addr_vld, 1);
    chk("unc2_uncor_cnt", uncor_cnt, 2);
    chk("unc2_state", state, 2);

    // saturation
    drive(0, 0, 0, '0, '0, 1);
    tick;
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 1, DW'(i), AW'(i), 0);
      tick;
      if (i == 253) chk("sat_254", cor_cnt, 254);
    end
    chk("sat_cor_cnt", cor_cnt, CMAX);

    // backpressure
    drive(0, 0, 0, '0, '0, 0);
    tick;
    out_ready = 1'b0;
    drive(1, 0, 0, 8'hA1, 10'h001, 0);
    tick;
    c0 = cor_cnt;
    u0 = uncor_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1, ~i[0], i[0], 8'hA2, 10'h002, 0);
      tick;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_data", out_data, 8'hA1);
      chk("bp_uncor_frozen", uncor_cnt, u0);
      chk("bp_cor_frozen", cor_cnt, c0);
    end
    out_ready = 1'b1;
    drive(1, 0, 0, 8'hA2, 10'h002, 0);
    tick;
    chk("bp_rel_data", out_data, 8'hA2);
    chk("bp_rel_uncor", uncor_cnt, u0);
    drive(1, 0, 0, 8'hA3, 10'h003, 0);
    tick;
    drive(0, 0, 0, '0, '0, 0);
    tick;

    // reset while stalled discards the held word
    out_ready = 1'b0;
    drive(1, 0, 0, 8'hB1, 10'h011, 0);
    tick;
    chk("stall_out_valid", out_valid, 1);
    drive(0, 0, 0, '0, '0, 0);
    rst_n = 1'b0;
    tick;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_cor_cnt", cor_cnt, 0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    tick;
    chk("drain_queue_empty", q.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
